// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: scancodes, key indices and sequencer states shared by the keyboard block
package ps2_kbd_pkg;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam int KEY_ENTER = 2;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 0;
    typedef enum logic [3:0] {
        INIT_SEND,
        INIT_WAIT_SENT,
        INIT_WAIT_ACK,
        INIT_WAIT_BAT,
        FAIL,
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;
endpackage

// File: rtl/ps2_kbd_sequencer_timer.sv
// ps2_wait_timer: saturating wait counter; tc holds once WAIT_CYCLES-1 is reached
module ps2_wait_timer #(
    parameter int WAIT_CYCLES = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    logic [W-1:0] cnt;
    assign tc = cnt == W'(WAIT_CYCLES - 1);
    always_ff @(posedge CLOCK_50) cnt <= clear ? '0 : enable && !tc ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/ps2_kbd_sequencer.sv
// ps2_kbd_sequencer: keyboard reset/ACK/BAT handshake with retries, then ENTER/LEFT/RIGHT decode
module ps2_kbd_sequencer
    import ps2_kbd_pkg::*;
#(
    parameter int WAIT_CYCLES = 50_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    output logic [7:0] the_command,
    output logic       send_command,
    output logic       ready,
    output logic       init_error,
    output logic [2:0] held,
    output logic [2:0] press
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    state_t state;
    logic [RW-1:0] retry;
    logic waiting, timer_clear, timed_out, retry_hit, last_try;
    assign the_command = CMD_RESET;
    assign waiting = state == INIT_WAIT_ACK || state == INIT_WAIT_BAT;
    assign timer_clear = reset || !waiting ||
                         (state == INIT_WAIT_ACK && received_data_en && received_data == SC_ACK);
    assign last_try = retry == RW'(MAX_RETRY - 1);
    // A byte arriving in the same cycle as a timeout or error always wins
    always_comb
        retry_hit = received_data_en ? state == INIT_WAIT_BAT && received_data == SC_BAT_FAIL
                  : state == INIT_WAIT_SENT ? error_communication_timed_out && !command_was_sent
                  : waiting && timed_out;
    ps2_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .CLOCK_50(CLOCK_50),
        .clear(timer_clear),
        .enable(waiting),
        .tc(timed_out)
    );
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= INIT_SEND;
            retry        <= '0;
            send_command <= 1'b0;
            ready        <= 1'b0;
            init_error   <= 1'b0;
            held         <= '0;
            press        <= '0;
        end else begin
            send_command <= 1'b0;
            press        <= '0;
            if (retry_hit) begin
                retry      <= retry + 1'b1;
                state      <= last_try ? FAIL : INIT_SEND;
                init_error <= last_try;
            end else begin
                case (state)
                    INIT_SEND: begin
                        send_command <= 1'b1;
                        state        <= INIT_WAIT_SENT;
                    end
                    INIT_WAIT_SENT: if (command_was_sent) state <= INIT_WAIT_ACK;
                    INIT_WAIT_ACK: if (received_data_en && received_data == SC_ACK) state <= INIT_WAIT_BAT;
                    INIT_WAIT_BAT: if (received_data_en && received_data == SC_BAT_OK) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                    IDLE: if (received_data_en) begin
                        state <= received_data == SC_EXT ? EXT : received_data == SC_BREAK ? BRK : IDLE;
                        if (received_data == SC_ENTER) begin
                            held[KEY_ENTER]  <= 1'b1;
                            press[KEY_ENTER] <= !held[KEY_ENTER];
                        end
                        if (received_data == SC_BAT_OK) held <= '0;
                    end
                    EXT: if (received_data_en) begin
                        state <= received_data == SC_BREAK ? EXT_BRK : IDLE;
                        if (received_data == SC_LEFT) begin
                            held[KEY_LEFT]  <= 1'b1;
                            press[KEY_LEFT] <= !held[KEY_LEFT];
                        end
                        if (received_data == SC_RIGHT) begin
                            held[KEY_RIGHT]  <= 1'b1;
                            press[KEY_RIGHT] <= !held[KEY_RIGHT];
                        end
                    end
                    BRK: if (received_data_en) begin
                        state <= IDLE;
                        if (received_data == SC_ENTER) held[KEY_ENTER] <= 1'b0;
                    end
                    EXT_BRK: if (received_data_en) begin
                        state <= IDLE;
                        if (received_data == SC_LEFT) held[KEY_LEFT] <= 1'b0;
                        if (received_data == SC_RIGHT) held[KEY_RIGHT] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbd_sequencer.sv
// tb_ps2_kbd_sequencer: random and directed scancode traffic checked against a flag-based keyboard model
module tb_ps2_kbd_sequencer;
    localparam int W  = 100;
    localparam int MR = 3;
    localparam int P_SEND = 0, P_SENT = 1, P_ACK = 2, P_BAT = 3, P_RDY = 4, P_FAIL = 5;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] the_command;
    logic       send_command, ready, init_error;
    logic [2:0] held, press;
    int vectors = 0, miscompares = 0, cyc = 0, n_sends = 0;
    int send_cyc[$];
    bit started = 0;
    int m_phase = P_SEND, m_tries = 0, m_el = 0;
    bit m_ext = 0, m_brk = 0, m_ready = 0, m_err = 0, m_send = 0;
    logic [2:0] m_held = '0, m_press = '0;

    ps2_kbd_sequencer #(.WAIT_CYCLES(W), .MAX_RETRY(MR)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .received_data(received_data),
        .received_data_en(received_data_en),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .the_command(the_command),
        .send_command(send_command),
        .ready(ready),
        .init_error(init_error),
        .held(held),
        .press(press)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Reference: init as a phase plus elapsed-cycle count, decode as prefix flags over the byte stream
    always @(posedge CLOCK_50) begin : model
        int ph, tries, el;
        bit ext, brk, rdy, er, snd, rt;
        logic [2:0] hd, pr;
        logic [7:0] d;
        ph = m_phase; tries = m_tries; el = m_el; ext = m_ext; brk = m_brk;
        rdy = m_ready; er = m_err; hd = m_held; pr = '0; snd = 0; rt = 0;
        d = received_data;
        if (reset) begin
            ph = P_SEND; tries = 0; el = 0; ext = 0; brk = 0; rdy = 0; er = 0; hd = '0;
        end else begin
            case (ph)
                P_SEND: begin snd = 1; ph = P_SENT; end
                P_SENT: if (command_was_sent) begin ph = P_ACK; el = 0; end
                        else if (error_communication_timed_out && !received_data_en) rt = 1;
                P_ACK: if (received_data_en && d == 8'hFA) begin ph = P_BAT; el = 0; end
                       else if (!received_data_en && el >= W - 1) rt = 1;
                       else el++;
                P_BAT: if (received_data_en && d == 8'hAA) begin ph = P_RDY; rdy = 1; end
                       else if (received_data_en && d == 8'hFC) rt = 1;
                       else if (!received_data_en && el >= W - 1) rt = 1;
                       else el++;
                P_RDY: if (received_data_en) begin
                    if (!ext && !brk) begin
                        if (d == 8'hE0) ext = 1;
                        else if (d == 8'hF0) brk = 1;
                        else if (d == 8'h5A) begin pr[2] = !hd[2]; hd[2] = 1; end
                        else if (d == 8'hAA) hd = '0;
                    end else if (ext && !brk) begin
                        if (d == 8'hF0) brk = 1;
                        else begin
                            ext = 0;
                            if (d == 8'h6B) begin pr[1] = !hd[1]; hd[1] = 1; end
                            else if (d == 8'h74) begin pr[0] = !hd[0]; hd[0] = 1; end
                        end
                    end else if (!ext) begin
                        if (d == 8'h5A) hd[2] = 0;
                        brk = 0;
                    end else begin
                        if (d == 8'h6B) hd[1] = 0;
                        else if (d == 8'h74) hd[0] = 0;
                        ext = 0; brk = 0;
                    end
                end
                default: ;
            endcase
            if (rt) begin
                tries++;
                if (tries == MR) begin ph = P_FAIL; er = 1; end
                else ph = P_SEND;
            end
        end
        m_phase <= ph; m_tries <= tries; m_el <= el; m_ext <= ext; m_brk <= brk;
        m_ready <= rdy; m_err <= er; m_held <= hd; m_press <= pr; m_send <= snd;
    end

    always @(negedge CLOCK_50) if (started) begin
        vectors++;
        if ({the_command, send_command, ready, init_error, held, press} !==
            {8'hFF, m_send, m_ready, m_err, m_held, m_press}) begin
            miscompares++;
            $display("FAIL model cyc=%0d got cmd=%h send=%b rdy=%b err=%b held=%b press=%b want cmd=ff send=%b rdy=%b err=%b held=%b press=%b",
                     cyc, the_command, send_command, ready, init_error, held, press,
                     m_send, m_ready, m_err, m_held, m_press);
        end
        if (!$onehot0(press)) begin
            miscompares++;
            $display("FAIL press_onehot cyc=%0d got %b want at most one bit", cyc, press);
        end
        if (send_command) begin
            n_sends++;
            send_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic send_byte(input logic [7:0] b);
        received_data = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (send_command) begin ok = 1; break; end
            @(negedge CLOCK_50);
        end
        chk("send_seen", 32'(ok), 1);
    endtask

    // mode 0: clean init; 1: BAT failure first; 2: transmit error first
    task automatic do_init(input int mode);
        int s0;
        bit ok;
        s0 = n_sends;
        reset = 1'b1; idle(2); reset = 1'b0;
        for (int a = 0; a < 2; a++) begin
            wait_send(ok);
            if (!ok) return;
            idle($urandom_range(0, 2));
            if (a == 0 && mode == 2) begin
                error_communication_timed_out = 1'b1; idle(1); error_communication_timed_out = 1'b0;
                continue;
            end
            command_was_sent = 1'b1; idle(1); command_was_sent = 1'b0;
            chk("send_width", 32'(send_command), 0);
            idle($urandom_range(0, 3));
            send_byte(8'h33);
            send_byte(8'hFA);
            idle($urandom_range(0, 3));
            send_byte(8'h12);
            if (a == 0 && mode == 1) begin send_byte(8'hFC); continue; end
            send_byte(8'hAA);
            chk("ready_after_bat", 32'(ready), 1);
            chk("model_ready", 32'(m_ready), 1);
            break;
        end
        idle(2);
        chk("init_sends", 32'(n_sends - s0), mode == 0 ? 1 : 2);
        chk("init_error_clear", 32'(init_error), 0);
    endtask

    task automatic random_bytes(input int n);
        logic [7:0] pool [8];
        logic [7:0] b;
        pool = '{8'h5A, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h00};
        for (int i = 0; i < n; i++) begin
            b = pool[$urandom_range(0, 7)];
            if (b == 8'h00) b = 8'($urandom);
            send_byte(b);
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        int s0, k;
        idle(1);
        started = 1;
        chk("rst_send", 32'(send_command), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_err", 32'(init_error), 0);
        chk("rst_held", 32'(held), 0);
        chk("rst_press", 32'(press), 0);
        chk("rst_cmd", 32'(the_command), 32'hFF);
        do_init(0);
        send_byte(8'hE0); send_byte(8'h6B);
        chk("left_press", 32'(press), 32'b010);
        chk("left_held", 32'(held), 32'b010);
        idle(1);
        send_byte(8'hE0); send_byte(8'h6B);
        chk("left_repeat_press", 32'(press), 0);
        chk("left_repeat_held", 32'(held), 32'b010);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        chk("left_release", 32'(held), 0);
        send_byte(8'h5A);
        chk("enter_press", 32'(press), 32'b100);
        send_byte(8'hE0); idle(1); send_byte(8'h74);
        chk("right_press", 32'(press), 32'b001);
        chk("held_101", 32'(held), 32'b101);
        send_byte(8'hF0); send_byte(8'h5A);
        chk("enter_release", 32'(held), 32'b001);
        send_byte(8'h5A);
        chk("held_101_again", 32'(held), 32'b101);
        send_byte(8'hAA);
        chk("hotplug_held", 32'(held), 0);
        chk("hotplug_press", 32'(press), 0);
        random_bytes(300);
        send_byte(8'h5A); send_byte(8'hE0);
        reset = 1'b1; idle(1);
        chk("midrst_outputs", 32'({send_command, ready, init_error, held, press}), 0);
        reset = 1'b0;
        send_byte(8'hE0); send_byte(8'h74);
        chk("preinit_press", 32'(press), 0);
        chk("preinit_held", 32'(held), 0);
        do_init(2);
        send_byte(8'hE0); send_byte(8'h74);
        chk("reinit_right_press", 32'(press), 32'b001);
        s0 = n_sends;
        reset = 1'b1; idle(2); reset = 1'b0;
        for (int i = 0; i < 5 * W; i++) begin
            command_was_sent = send_command;
            @(negedge CLOCK_50);
        end
        command_was_sent = 1'b0;
        chk("retry_sends", 32'(n_sends - s0), 3);
        chk("retry_err", 32'(init_error), 1);
        chk("retry_ready", 32'(ready), 0);
        k = send_cyc.size();
        if (k >= 3) begin
            chk("retry_gap1", 32'(send_cyc[k-2] - send_cyc[k-3]), W + 2);
            chk("retry_gap2", 32'(send_cyc[k-1] - send_cyc[k-2]), W + 2);
        end
        do_init(1);
        random_bytes(100);
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
